// File: rtl/clock_edit_ctrl_if.sv
// rtl/clock_edit_ctrl_if.sv - key inputs and control outputs of the clock edit controller
interface clock_edit_ctrl_if;
  logic [3:0] KEY;
  logic       secTick;
  logic       editMode;
  logic [2:0] editCur;
  logic [1:0] disMode;
  logic       incPulse;
  logic       decPulse;
  logic       blink;

  modport master (
    output KEY,
    input  secTick, editMode, editCur, disMode, incPulse, decPulse, blink
  );

  modport slave (
    input  KEY,
    output secTick, editMode, editCur, disMode, incPulse, decPulse, blink
  );
endinterface

// File: rtl/clock_edit_ctrl.sv
// rtl/clock_edit_ctrl.sv - key debounce, RUN/EDIT mode FSM, 1 Hz tick, edit timeout and cursor blink
module clock_edit_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int DEB_CYCLES = 500000,
  parameter int TIMEOUT_S  = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  clock_edit_ctrl_if.slave  bus
);

  localparam int QTR_HZ = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int PW     = (CLK_HZ > 1)     ? $clog2(CLK_HZ)     : 1;
  localparam int DW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW     = (TIMEOUT_S > 1)  ? $clog2(TIMEOUT_S)  : 1;
  localparam int BW     = (QTR_HZ > 1)     ? $clog2(QTR_HZ)     : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_S - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(QTR_HZ - 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  logic [3:0]          sync1_q, sync2_q;
  logic [1:0]          fill_q, fill_d;
  logic [3:0]          pressed_q, pressed_d;
  logic [3:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]          ev;

  logic mode_ev, next_ev, up_ev;

  state_t              state_q, state_d;
  logic [2:0]          edit_cur_q, edit_cur_d;
  logic [1:0]          dis_mode_q, dis_mode_d;
  logic                inc_q, inc_d;
  logic                dec_q, dec_d;
  logic                tick_q, tick_d;
  logic                blink_q, blink_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [PW-1:0]       ecnt_q, ecnt_d;
  logic [TW-1:0]       idle_q, idle_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;

  // Debounce waits two cycles after reset so the synchronizer's reset value
  // cannot be mistaken for a release of a key that is physically held.
  always_comb begin
    ev        = '0;
    pressed_d = pressed_q;
    deb_cnt_d = deb_cnt_q;
    fill_d    = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    if (fill_q == 2'd2) begin
      for (int i = 0; i < 4; i++) begin
        if (!pressed_q[i]) begin
          if (sync2_q[i]) begin
            deb_cnt_d[i] = '0;
          end else if (deb_cnt_q[i] == DEB_LAST) begin
            ev[i]        = 1'b1;
            pressed_d[i] = 1'b1;
            deb_cnt_d[i] = '0;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
          end
        end else begin
          if (!sync2_q[i]) begin
            deb_cnt_d[i] = '0;
          end else if (deb_cnt_q[i] == DEB_LAST) begin
            pressed_d[i] = 1'b0;
            deb_cnt_d[i] = '0;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
          end
        end
      end
    end
  end

  assign mode_ev = ev[0];
  assign next_ev = ev[3] & ~ev[0];
  assign up_ev   = ev[1] & ~ev[3] & ~ev[0];

  always_comb begin
    state_d    = state_q;
    edit_cur_d = edit_cur_q;
    dis_mode_d = dis_mode_q;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    ecnt_d     = ecnt_q;
    idle_d     = idle_q;

    case (state_q)
      ST_RUN: begin
        if (mode_ev) begin
          if (dis_mode_q == 2'd0) begin
            state_d    = ST_EDIT;
            edit_cur_d = 3'd0;
          end else begin
            dis_mode_d = 2'd0;
          end
        end else if (next_ev) begin
          dis_mode_d = (dis_mode_q == 2'd2) ? 2'd0 : dis_mode_q + 2'd1;
        end
      end
      ST_EDIT: begin
        // Any accepted press restarts the idle timer, even one landing on the timeout cycle.
        if (|ev) begin
          ecnt_d = '0;
          idle_d = '0;
          if (mode_ev) begin
            state_d = ST_RUN;
          end else if (next_ev) begin
            edit_cur_d = (edit_cur_q == 3'd5) ? 3'd0 : edit_cur_q + 3'd1;
          end else if (up_ev) begin
            inc_d = 1'b1;
          end else begin
            dec_d = 1'b1;
          end
        end else if (ecnt_q == PRESC_LAST) begin
          ecnt_d = '0;
          if (idle_q == IDLE_LAST) begin
            state_d = ST_RUN;
          end else begin
            idle_d = idle_q + TW'(1);
          end
        end else begin
          ecnt_d = ecnt_q + PW'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (state_d == ST_RUN) begin
      edit_cur_d = 3'd0;
      ecnt_d     = '0;
      idle_d     = '0;
    end
  end

  // Prescaler only advances across consecutive RUN cycles, so a return
  // from EDIT restarts it at zero and the next tick is a full second away.
  always_comb begin
    presc_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end
    tick_d = (state_d == ST_RUN) && (presc_d == PRESC_LAST);
  end

  always_comb begin
    bcnt_d  = '0;
    blink_d = 1'b1;
    if (state_q == ST_EDIT && state_d == ST_EDIT) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
        blink_d = blink_q;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      fill_q     <= '0;
      pressed_q  <= 4'hF;
      deb_cnt_q  <= '0;
      state_q    <= ST_RUN;
      edit_cur_q <= 3'd0;
      dis_mode_q <= 2'd0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      tick_q     <= 1'b0;
      blink_q    <= 1'b1;
      presc_q    <= '0;
      ecnt_q     <= '0;
      idle_q     <= '0;
      bcnt_q     <= '0;
    end else begin
      sync1_q    <= bus.KEY;
      sync2_q    <= sync1_q;
      fill_q     <= fill_d;
      pressed_q  <= pressed_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      edit_cur_q <= edit_cur_d;
      dis_mode_q <= dis_mode_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      tick_q     <= tick_d;
      blink_q    <= blink_d;
      presc_q    <= presc_d;
      ecnt_q     <= ecnt_d;
      idle_q     <= idle_d;
      bcnt_q     <= bcnt_d;
    end
  end

  assign bus.secTick  = tick_q;
  assign bus.editMode = (state_q == ST_EDIT);
  assign bus.editCur  = edit_cur_q;
  assign bus.disMode  = dis_mode_q;
  assign bus.incPulse = inc_q;
  assign bus.decPulse = dec_q;
  assign bus.blink    = blink_q;

endmodule

// File: tb/tb_clock_edit_ctrl.sv
// tb/tb_clock_edit_ctrl.sv - self-checking bench for clock_edit_ctrl
module tb_clock_edit_ctrl;
  localparam int C = 8;
  localparam int D = 2;
  localparam int T = 3;
  localparam int Q = C / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  clock_edit_ctrl_if bus();

  clock_edit_ctrl #(.CLK_HZ(C), .DEB_CYCLES(D), .TIMEOUT_S(T)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int n_inc = 0, n_dec = 0, n_tick = 0, n_entry = 0;
  int edit_len = 0, last_edit_len = 0, inc_cur = -1;
  bit prev_edit = 1'b0;

  // behavioural reference: run lengths of the synchronized keys and cycle indices per mode
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF;
  int m_low[4], m_high[4];
  bit m_armed[4];
  int m_since_rst = 0;
  bit m_edit = 1'b0;
  int m_cur = 0, m_dis = 0;
  bit m_inc = 1'b0, m_dec = 1'b0, m_tick = 1'b0, m_blink = 1'b1;
  int m_run_idx = 0, m_edit_idx = 0, m_idle = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] evs;
    bit next_edit;
    int idle_n;
    if (!rst_n) begin
      m_s1 = 4'hF; m_s2 = 4'hF;
      for (int i = 0; i < 4; i++) begin m_low[i] = 0; m_high[i] = 0; m_armed[i] = 1'b0; end
      m_since_rst = 0; m_edit = 1'b0; m_cur = 0; m_dis = 0;
      m_inc = 1'b0; m_dec = 1'b0; m_tick = 1'b0; m_blink = 1'b1;
      m_run_idx = 0; m_edit_idx = 0; m_idle = 0;
      return;
    end
    evs = '0;
    if (m_since_rst >= 2) begin
      for (int i = 0; i < 4; i++) begin
        if (!m_s2[i]) begin
          m_low[i]++; m_high[i] = 0;
          if (m_armed[i] && m_low[i] == D) begin evs[i] = 1'b1; m_armed[i] = 1'b0; end
        end else begin
          m_high[i]++; m_low[i] = 0;
          if (m_high[i] >= D) m_armed[i] = 1'b1;
        end
      end
    end
    m_since_rst++;
    m_s2 = m_s1;
    m_s1 = bus.KEY;

    m_inc = 1'b0; m_dec = 1'b0;
    next_edit = m_edit;
    idle_n = 0;
    if (!m_edit) begin
      if (evs[0]) begin
        if (m_dis == 0) next_edit = 1'b1; else m_dis = 0;
      end else if (evs[3]) begin
        m_dis = (m_dis + 1) % 3;
      end
    end else begin
      if (evs != 0) begin
        if (evs[0]) next_edit = 1'b0;
        else if (evs[3]) m_cur = (m_cur + 1) % 6;
        else if (evs[1]) m_inc = 1'b1;
        else m_dec = 1'b1;
      end else if (m_idle == T * C - 1) begin
        next_edit = 1'b0;
      end else begin
        idle_n = m_idle + 1;
      end
    end

    if (next_edit) begin
      m_edit_idx = m_edit ? m_edit_idx + 1 : 0;
      m_idle     = m_edit ? idle_n : 0;
      if (!m_edit) m_cur = 0;
      m_tick  = 1'b0;
      m_blink = ((m_edit_idx / Q) % 2) == 0;
    end else begin
      m_run_idx = m_edit ? 0 : m_run_idx + 1;
      m_cur   = 0;
      m_blink = 1'b1;
      m_tick  = (m_run_idx % C) == C - 1;
    end
    m_edit = next_edit;
  endtask

  always begin
    logic [9:0] act_v, exp_v;
    @(posedge clk);
    model_step();
    #1;
    act_v = {bus.editMode, bus.editCur, bus.disMode, bus.secTick, bus.incPulse, bus.decPulse, bus.blink};
    exp_v = {m_edit, 3'(m_cur), 2'(m_dis), m_tick, m_inc, m_dec, m_blink};
    check($sformatf("outputs@%0t(edit,cur,dis,tick,inc,dec,blink)", $time), int'(act_v), int'(exp_v));
    if (bus.incPulse) begin n_inc++; inc_cur = int'(bus.editCur); end
    if (bus.decPulse) n_dec++;
    if (bus.secTick) n_tick++;
    if (bus.editMode && !prev_edit) n_entry++;
    if (bus.editMode) edit_len++;
    else if (edit_len > 0) begin last_edit_len = edit_len; edit_len = 0; end
    prev_edit = bus.editMode;
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(logic [3:0] k, int hold, int rel);
    bus.KEY = k;
    cyc(hold);
    bus.KEY = 4'hF;
    cyc(rel);
  endtask

  typedef struct {
    logic [3:0] key;
    bit         exp_edit;
    int         exp_cur;
    int         exp_dis;
    int         exp_inc;
    int         exp_dec;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int i0, d0, t0, e0, tg;
    logic pb;

    for (int i = 0; i < 7; i++) tbl[i] = '{4'b0111, 1'b1, (i + 1) % 6, 0, 0, 0};
    tbl[7]  = '{4'b1101, 1'b1, 1, 0, 1, 0};
    tbl[8]  = '{4'b1011, 1'b1, 1, 0, 0, 1};
    tbl[9]  = '{4'b1110, 1'b0, 0, 0, 0, 0};
    tbl[10] = '{4'b0111, 1'b0, 0, 1, 0, 0};
    tbl[11] = '{4'b0111, 1'b0, 0, 2, 0, 0};
    tbl[12] = '{4'b1101, 1'b0, 0, 2, 0, 0};
    tbl[13] = '{4'b1110, 1'b0, 0, 0, 0, 0};
    tbl[14] = '{4'b0111, 1'b0, 0, 1, 0, 0};
    tbl[15] = '{4'b0111, 1'b0, 0, 2, 0, 0};
    tbl[16] = '{4'b0111, 1'b0, 0, 0, 0, 0};
    tbl[17] = '{4'b1110, 1'b1, 0, 0, 0, 0};
    tbl[18] = '{4'b1110, 1'b0, 0, 0, 0, 0};

    bus.KEY = 4'hF;
    rst_n   = 1'b0;
    cyc(3);
    check("reset_blink", int'(bus.blink), 1);
    check("reset_edit", int'(bus.editMode), 0);
    rst_n = 1'b1;

    t0 = n_tick;
    cyc(40);
    check("ticks_in_40", n_tick - t0, 5);
    check("idle_dis", int'(bus.disMode), 0);
    check("idle_pulses", n_inc + n_dec, 0);

    t0 = n_tick;
    press(4'b1110, 5, 1);
    check("enter_edit", int'(bus.editMode), 1);
    check("enter_cur", int'(bus.editCur), 0);
    pb = bus.blink;
    tg = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (bus.blink != pb) tg++;
      pb = bus.blink;
    end
    check("blink_toggles", tg, 4);
    check("edit_no_tick", n_tick - t0, 0);

    for (int i = 0; i < 19; i++) begin
      i0 = n_inc; d0 = n_dec;
      press(tbl[i].key, 5, 5);
      check($sformatf("tbl%0d_edit", i), int'(bus.editMode), int'(tbl[i].exp_edit));
      check($sformatf("tbl%0d_cur", i), int'(bus.editCur), tbl[i].exp_cur);
      check($sformatf("tbl%0d_dis", i), int'(bus.disMode), tbl[i].exp_dis);
      check($sformatf("tbl%0d_inc", i), n_inc - i0, tbl[i].exp_inc);
      check($sformatf("tbl%0d_dec", i), n_dec - d0, tbl[i].exp_dec);
    end
    check("inc_cursor", inc_cur, 1);

    press(4'b1110, 5, 5);
    i0 = n_inc; d0 = n_dec;
    press(4'b1001, 5, 5);
    check("updown_inc", n_inc - i0, 1);
    check("updown_dec", n_dec - d0, 0);
    press(4'b0110, 5, 5);
    check("modenext_edit", int'(bus.editMode), 0);
    check("modenext_dis", int'(bus.disMode), 0);

    i0 = n_inc; d0 = n_dec;
    press(4'b1110, 5, 1);
    cyc(30);
    check("timeout_len", last_edit_len, T * C);
    check("timeout_edit", int'(bus.editMode), 0);
    check("timeout_cur", int'(bus.editCur), 0);
    check("timeout_pulses", (n_inc - i0) + (n_dec - d0), 0);

    press(4'b1110, 5, 0);
    cyc(19);
    d0 = n_dec;
    press(4'b1011, 5, 1);
    check("late_press_edit", int'(bus.editMode), 1);
    check("late_press_dec", n_dec - d0, 1);
    cyc(30);
    check("late_press_exit", int'(bus.editMode), 0);

    e0 = n_entry;
    for (int i = 0; i < 10; i++) begin
      bus.KEY = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      cyc(1);
    end
    bus.KEY = 4'b1110;
    cyc(3);
    bus.KEY = 4'hF;
    cyc(6);
    check("bounce_events", n_entry - e0, 1);
    check("bounce_edit", int'(bus.editMode), 1);

    i0 = n_inc;
    bus.KEY = 4'b1101;
    cyc(2);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    bus.KEY = 4'hF;
    cyc(6);
    check("rst_edit", int'(bus.editMode), 0);
    check("rst_no_inc", n_inc - i0, 0);

    e0 = n_entry;
    bus.KEY = 4'b1110;
    cyc(2);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(12);
    check("held_over_rst", n_entry - e0, 0);
    bus.KEY = 4'hF;
    cyc(6);
    press(4'b1110, 5, 5);
    check("rearm_after_rst", int'(bus.editMode), 1);
    press(4'b1110, 5, 5);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end
      bus.KEY = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      cyc($urandom_range(1, 6));
    end
    bus.KEY = 4'hF;
    cyc(40);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/clock_edit_ctrl.md
CLOCK_EDIT_CTRL -- requirements
Module: clock_edit_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CLK_HZ, 50000000, Clk frequency; one secTick every CLK_HZ cycles.
- DEB_CYCLES, 500000, cycles a key must stay low before a press is accepted.
- TIMEOUT_S, 10, seconds without an accepted press before edit mode auto-exits.
REQ-002 Ports, one per line: name, direction, width, meaning.
- Clk, input, 1, single system clock; all state updates on posedge Clk.
- Reset_n, input, 1, synchronous active-low reset, sampled on posedge Clk.
- KEY, input, 4, raw active-low push buttons (asynchronous, bouncing).
  - [0] mode
  - [1] up
  - [2] down
  - [3] next
- secTick, output, 1, one-cycle 1 Hz enable to the time counters.
- editMode, output, 1, 1 = EDIT state.
- editCur, output, 3, edited digit: 0/1 hour tens/ones, 2/3 minute tens/ones, 4/5 second tens/ones.
- disMode, output, 2, display page 0..2 (0 = time).
- incPulse, output, 1, one-cycle increment request for digit editCur.
- decPulse, output, 1, one-cycle decrement request for digit editCur.
- blink, output, 1, 2 Hz square wave for cursor-digit flashing; forced 1 outside EDIT.

Function
REQ-003 Each KEY bit SHALL pass a 2-flop synchronizer before any other use.
REQ-004 Debounce: a press event SHALL fire on the cycle the synchronized key has been low for exactly DEB_CYCLES consecutive cycles.
- Exactly one event per press.
- Release is re-armed only after the key has been high for DEB_CYCLES consecutive cycles.
REQ-005 Event priority SHALL be mode > next > up > down. Only the highest-priority event in a cycle is acted on; the others are discarded, not queued.
REQ-006 FSM states SHALL be RUN and EDIT.
REQ-007 In RUN:
- next: disMode SHALL step 0→1→2→0.
- mode with disMode==0: SHALL enter EDIT with editCur=0.
- mode with disMode!=0: SHALL set disMode=0 and stay in RUN.
- up/down: ignored.
REQ-008 In EDIT:
- next: editCur SHALL step 0→1→…→5→0.
- up: incPulse=1 for exactly one cycle.
- down: decPulse=1 for exactly one cycle.
- mode: return to RUN.
- disMode SHALL hold 0.
REQ-009 Pulse timing: incPulse/decPulse SHALL assert the cycle after the event cycle, with editCur valid and stable in that same cycle. The two SHALL never assert together.
REQ-010 Tick prescaler: a counter SHALL run 0..CLK_HZ-1. secTick SHALL be 1 on the count==CLK_HZ-1 cycle in RUN only.
- In EDIT the prescaler SHALL hold at 0 and secTick SHALL be 0, so time is frozen.
- On EDIT→RUN the first secTick SHALL follow a full CLK_HZ cycles later.
REQ-011 Timeout: in EDIT an idle-seconds counter SHALL clear on every accepted event and increment once per CLK_HZ cycles.
- On reaching TIMEOUT_S: EDIT→RUN, editCur=0, no pulse.
- An event in the same cycle as the timeout wins: the timeout is suppressed and the counter clears.
REQ-012 blink SHALL toggle every CLK_HZ/4 cycles in EDIT and restart high on EDIT entry.
REQ-013 Leaving EDIT by any means SHALL force editCur=0 and blink=1 on the next cycle.
REQ-014 All counters SHALL be sized for their parameter maximum and SHALL never wrap past their terminal value.

Reset
REQ-015 With Reset_n low at posedge Clk, the following SHALL hold from the next cycle:
- state=RUN, editMode=0, editCur=0, disMode=0
- secTick=0, incPulse=0, decPulse=0, blink=1
- all prescaler, debounce and timeout counters = 0
- synchronizers = 1 (keys released)
REQ-016 Reset asserted mid-press or mid-EDIT SHALL abort the operation with no pulse emitted. A key still held when Reset_n rises SHALL NOT generate an event until it is released and pressed again.

Verification (CLK_HZ=8, DEB_CYCLES=2, TIMEOUT_S=3)
REQ-017 Reset, keys released, 40 cycles:
- secTick high on cycles 8, 16, 24, 32, 40 after reset release.
- All other outputs at reset values.
REQ-018 Press KEY[0] for 5 cycles:
- editMode=1, editCur=0.
- secTick stays 0.
- blink toggles every 2 cycles.
REQ-019 In EDIT, press KEY[3] ×7, then KEY[1] ×1:
- editCur sequence 1,2,3,4,5,0,1.
- Exactly one incPulse, with editCur=1.
REQ-020 In EDIT, press KEY[1] and KEY[2] simultaneously:
- One incPulse, no decPulse.
- Then KEY[0] and KEY[3] simultaneously: return to RUN, disMode stays 0.
REQ-021 In EDIT, no keys for 24 cycles: editMode=0, editCur=0, no pulses.
- Repeat, pressing KEY[2] at cycle 23: EDIT persists and one decPulse.
REQ-022 Bounce and reset cases:
- KEY[0] bouncing low/high on alternate cycles for 10 cycles, then held low 3 cycles: exactly one event.
- Reset_n pulsed low while KEY[1] held in EDIT: RUN, no incPulse.
